// File: rtl/dac_spi_ctl.sv
// Threshold DAC responder: captures a requested code and shifts {CMD, code} MSB first over 3-wire SPI,
// holding threshold_rdy_o low until the frame is sent and the DAC output has settled.
module dac_spi_ctl #(
   parameter int                DATA_W        = 16,
   parameter int                CMD_W         = 8,
   parameter logic [CMD_W-1:0]  CMD           = 8'h30,
   parameter int                CLK_DIV       = 4,
   parameter int                SETTLE_CYCLES = 20,
   parameter logic [DATA_W-1:0] RESET_CODE    = '0
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic [DATA_W-1:0] threshold_i,
   input  logic              threshold_wre_i,
   output logic              threshold_rdy_o,
   output logic [DATA_W-1:0] dac_code_o,
   output logic              dac_cs_n_o,
   output logic              dac_sclk_o,
   output logic              dac_mosi_o
);

   localparam int FRAME_W = CMD_W + DATA_W;
   localparam int DIV_MAX = (CLK_DIV > SETTLE_CYCLES) ? CLK_DIV : SETTLE_CYCLES;
   localparam int DIV_W   = $clog2(DIV_MAX + 1);
   localparam int BIT_W   = $clog2(FRAME_W + 1);

   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] SETTLE_LAST = DIV_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(FRAME_W - 1);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_SETTLE} state_t;

   state_t              state_q, state_n;
   logic [DIV_W-1:0]    div_q, div_n;
   logic [BIT_W-1:0]    bit_q, bit_n;
   logic [FRAME_W-1:0]  shreg_q, shreg_n;
   logic [DATA_W-1:0]   sent_q, sent_n;
   logic                pend_vld_q, pend_vld_n;
   logic [DATA_W-1:0]   pend_code_q, pend_code_n;
   logic                cs_n_q, cs_n_n;
   logic                sclk_q, sclk_n;
   logic                mosi_q, mosi_n;
   logic                rdy_q, rdy_n;
   logic [DATA_W-1:0]   code_q, code_n;

   logic                start;
   logic [DATA_W-1:0]   start_code;
   logic [FRAME_W-1:0]  frame;

   // NOTE: every signal written here gets its hold value first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_n     = state_q;
      div_n       = div_q;
      bit_n       = bit_q;
      shreg_n     = shreg_q;
      sent_n      = sent_q;
      pend_vld_n  = pend_vld_q;
      pend_code_n = pend_code_q;
      cs_n_n      = cs_n_q;
      sclk_n      = sclk_q;
      mosi_n      = mosi_q;
      rdy_n       = rdy_q;
      code_n      = code_q;
      start       = 1'b0;
      start_code  = threshold_i;
      frame       = '0;

      // Busy-time writes land in the one-deep pending slot; the last one wins.
      if (state_q != S_IDLE && threshold_wre_i) begin
         pend_vld_n  = 1'b1;
         pend_code_n = threshold_i;
      end

      unique case (state_q)
         S_INIT: begin
            start      = 1'b1;
            start_code = RESET_CODE;
         end
         S_IDLE: begin
            start = threshold_wre_i;
         end
         S_SETUP: begin
            if (div_q == DIV_LAST) begin
               state_n = S_SHIFT;
               div_n   = '0;
               bit_n   = '0;
               sclk_n  = 1'b1;
            end else begin
               div_n = div_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (div_q != DIV_LAST) begin
               div_n = div_q + 1'b1;
            end else begin
               div_n = '0;
               if (sclk_q) begin
                  sclk_n = 1'b0;
               end else if (bit_q == BIT_LAST) begin
                  state_n = S_HOLD;
               end else begin
                  // Next bit goes out on the rising edge so it is stable across the following fall.
                  sclk_n  = 1'b1;
                  bit_n   = bit_q + 1'b1;
                  shreg_n = {shreg_q[FRAME_W-2:0], 1'b0};
                  mosi_n  = shreg_q[FRAME_W-2];
               end
            end
         end
         S_HOLD: begin
            if (div_q != DIV_LAST) begin
               div_n = div_q + 1'b1;
            end else begin
               div_n  = '0;
               cs_n_n = 1'b1;
               mosi_n = 1'b0;
               code_n = sent_q;
               if (SETTLE_CYCLES == 0 && !(pend_vld_q || threshold_wre_i)) begin
                  state_n = S_IDLE;
                  rdy_n   = 1'b1;
               end else begin
                  state_n = S_SETTLE;
               end
            end
         end
         S_SETTLE: begin
            if (div_q != SETTLE_LAST) begin
               div_n = div_q + 1'b1;
            end else if (pend_vld_q || threshold_wre_i) begin
               start      = 1'b1;
               start_code = threshold_wre_i ? threshold_i : pend_code_q;
               pend_vld_n = 1'b0;
            end else begin
               state_n = S_IDLE;
               rdy_n   = 1'b1;
            end
         end
         default: state_n = S_INIT;
      endcase

      if (start) begin
         frame   = {CMD, start_code};
         state_n = S_SETUP;
         div_n   = '0;
         shreg_n = frame;
         sent_n  = start_code;
         cs_n_n  = 1'b0;
         sclk_n  = 1'b0;
         mosi_n  = frame[FRAME_W-1];
         rdy_n   = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q     <= S_INIT;
         div_q       <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         sent_q      <= '0;
         pend_vld_q  <= 1'b0;
         pend_code_q <= '0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         rdy_q       <= 1'b0;
         code_q      <= '0;
      end else begin
         state_q     <= state_n;
         div_q       <= div_n;
         bit_q       <= bit_n;
         shreg_q     <= shreg_n;
         sent_q      <= sent_n;
         pend_vld_q  <= pend_vld_n;
         pend_code_q <= pend_code_n;
         cs_n_q      <= cs_n_n;
         sclk_q      <= sclk_n;
         mosi_q      <= mosi_n;
         rdy_q       <= rdy_n;
         code_q      <= code_n;
      end
   end

   assign threshold_rdy_o = rdy_q;
   assign dac_code_o      = code_q;
   assign dac_cs_n_o      = cs_n_q;
   assign dac_sclk_o      = sclk_q;
   assign dac_mosi_o      = mosi_q;

endmodule
